// File: rtl/prog_sequencer.sv
// Fetch-control sequencer: Start/Ack program handshake, relative/absolute jumps,
// Zero-flag branches and a bounded call/return stack feeding InstROM.
module prog_sequencer #(
    parameter int PC_W    = 10,
    parameter int OFF_W   = 9,
    parameter int STACK_D = 4,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Done,
    input  logic               JmpEq,
    input  logic               JmpNe,
    input  logic               Jmp,
    input  logic               Call,
    input  logic               Ret,
    input  logic               Zero,
    input  logic               OffsetEn,
    input  logic [OFF_W-1:0]   Offset,
    input  logic [PC_W-1:0]    Target,
    output logic [PC_W-1:0]    ProgCtr,
    output logic               Ack,
    output logic               Busy,
    output logic               StackErr,
    output logic [CNT_W-1:0]   CycleCt
);

    localparam int SP_W  = $clog2(STACK_D + 1);
    localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_stack [STACK_D];
    logic [SP_W-1:0]     r_sp;
    logic [CNT_W-1:0]    r_cycle;
    logic                r_ack;
    logic                r_busy;
    logic                r_err;

    logic [PC_W-1:0]     w_pcInc;
    logic [PC_W-1:0]     w_offExt;
    logic [PC_W-1:0]     w_target;
    logic                w_taken;
    logic                w_stackEmpty;
    logic                w_stackFull;

    // PC arithmetic is modulo 2**PC_W; the sized cast sign-extends or truncates Offset.
    assign w_pcInc      = r_pc + PC_W'(1);
    assign w_offExt     = PC_W'($signed(Offset));
    assign w_target     = OffsetEn ? (r_pc + w_offExt) : Target;
    assign w_taken      = (JmpEq & Zero) | (JmpNe & ~Zero) | Jmp;
    assign w_stackEmpty = (r_sp == '0);
    assign w_stackFull  = (r_sp == SP_W'(STACK_D));

    // Start restarts from any state; within RUN, Done beats Ret beats Call beats branch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_sp    <= '0;
            r_cycle <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else if (Start) begin
            r_state <= RUN;
            r_pc    <= '0;
            r_sp    <= '0;
            r_cycle <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
        end else if (r_state == RUN) begin
            if (r_cycle != '1) begin
                r_cycle <= r_cycle + CNT_W'(1);
            end
            if (Done) begin
                r_state <= HALT;
                r_ack   <= 1'b1;
                r_busy  <= 1'b0;
            end else if (Ret) begin
                if (w_stackEmpty) begin
                    r_pc  <= w_pcInc;
                    r_err <= 1'b1;
                end else begin
                    r_pc <= r_stack[IDX_W'(r_sp - SP_W'(1))];
                    r_sp <= r_sp - SP_W'(1);
                end
            end else if (Call) begin
                // A full stack drops the push but the jump is still taken.
                if (w_stackFull) begin
                    r_err <= 1'b1;
                end else begin
                    r_stack[IDX_W'(r_sp)] <= w_pcInc;
                    r_sp                  <= r_sp + SP_W'(1);
                end
                r_pc <= w_target;
            end else if (w_taken) begin
                r_pc <= w_target;
            end else begin
                r_pc <= w_pcInc;
            end
        end
    end

    assign ProgCtr  = r_pc;
    assign Ack      = r_ack;
    assign Busy     = r_busy;
    assign StackErr = r_err;
    assign CycleCt  = r_cycle;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomised and directed bench for prog_sequencer, checked against a queue-based
// behavioural model; a second instance with a 4-bit cycle counter shares all inputs.
module tb_prog_sequencer;

    localparam int PC_W    = 10;
    localparam int OFF_W   = 9;
    localparam int STACK_D = 4;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int OFF_MOD = 1 << OFF_W;

    logic              Clk = 1'b0;
    logic              Reset, Start, Done, JmpEq, JmpNe, Jmp, Call, Ret, Zero, OffsetEn;
    logic [OFF_W-1:0]  Offset;
    logic [PC_W-1:0]   Target;
    logic [PC_W-1:0]   ProgCtr, progCtrSmall;
    logic              Ack, Busy, StackErr, ackSmall, busySmall, stackErrSmall;
    logic [15:0]       CycleCt;
    logic [3:0]        cycleCtSmall;

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model state: mode 0 = idle, 1 = run, 2 = halt
    int mMode, mPc, mCyc;
    bit mErr;
    int mStack[$];

    prog_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .STACK_D(STACK_D), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Done(Done), .JmpEq(JmpEq), .JmpNe(JmpNe),
        .Jmp(Jmp), .Call(Call), .Ret(Ret), .Zero(Zero), .OffsetEn(OffsetEn), .Offset(Offset),
        .Target(Target), .ProgCtr(ProgCtr), .Ack(Ack), .Busy(Busy), .StackErr(StackErr),
        .CycleCt(CycleCt)
    );

    prog_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .STACK_D(STACK_D), .CNT_W(4)) dutSmall (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Done(Done), .JmpEq(JmpEq), .JmpNe(JmpNe),
        .Jmp(Jmp), .Call(Call), .Ret(Ret), .Zero(Zero), .OffsetEn(OffsetEn), .Offset(Offset),
        .Target(Target), .ProgCtr(progCtrSmall), .Ack(ackSmall), .Busy(busySmall),
        .StackErr(stackErrSmall), .CycleCt(cycleCtSmall)
    );

    always #5 Clk = ~Clk;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic clearInputs();
        Reset = 0; Start = 0; Done = 0; JmpEq = 0; JmpNe = 0; Jmp = 0;
        Call = 0; Ret = 0; Zero = 0; OffsetEn = 0; Offset = '0; Target = '0;
    endtask

    function automatic int modelTarget();
        int off;
        if (!OffsetEn) return int'(Target);
        off = int'(Offset);
        if (off >= OFF_MOD / 2) off -= OFF_MOD;
        return (((mPc + off) % PC_MOD) + PC_MOD) % PC_MOD;
    endfunction

    // Behavioural update using the inputs present at the clock edge.
    task automatic modelStep();
        int tgt;
        tgt = modelTarget();
        if (Reset) begin
            mMode = 0; mPc = 0; mCyc = 0; mErr = 0; mStack.delete();
        end else if (Start) begin
            mMode = 1; mPc = 0; mCyc = 0; mErr = 0; mStack.delete();
        end else if (mMode == 1) begin
            mCyc++;
            if (Done) begin
                mMode = 2;
            end else if (Ret) begin
                if (mStack.size() > 0) mPc = mStack.pop_back();
                else begin mPc = (mPc + 1) % PC_MOD; mErr = 1; end
            end else if (Call) begin
                if (mStack.size() < STACK_D) mStack.push_back((mPc + 1) % PC_MOD);
                else mErr = 1;
                mPc = tgt;
            end else if ((JmpEq && Zero) || (JmpNe && !Zero) || Jmp) begin
                mPc = tgt;
            end else begin
                mPc = (mPc + 1) % PC_MOD;
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("ProgCtr", ProgCtr, mPc);
        checkOutput("Ack", Ack, (mMode == 2) ? 1 : 0);
        checkOutput("Busy", Busy, (mMode == 1) ? 1 : 0);
        checkOutput("StackErr", StackErr, mErr);
        checkOutput("CycleCt", CycleCt, (mCyc > 65535) ? 65535 : mCyc);
        checkOutput("CycleCtSmall", cycleCtSmall, (mCyc > 15) ? 15 : mCyc);
    endtask

    // Apply the currently driven inputs for one cycle, then check against the model.
    task automatic applyStimulus();
        @(posedge Clk);
        modelStep();
        #1;
        compareAll();
        clearInputs();
    endtask

    task automatic nopCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic doStart();
        Start = 1; applyStimulus();
    endtask

    initial begin
        clearInputs();
        mMode = 0; mPc = 0; mCyc = 0; mErr = 0;
        Reset = 1; applyStimulus();
        Reset = 1; applyStimulus();
        checkOutput("resetPc", ProgCtr, 0);
        checkOutput("resetBusy", Busy, 0);
        nopCycles(2);

        // Basic run then Done
        doStart();
        nopCycles(5);
        Done = 1; applyStimulus();
        checkOutput("haltPc", ProgCtr, 5);
        checkOutput("haltCyc", CycleCt, 6);
        checkOutput("haltAck", Ack, 1);
        JmpEq = 1; Zero = 1; Target = 10'd77; applyStimulus();
        checkOutput("haltIgnoresStrobes", ProgCtr, 5);

        // Conditional branches
        doStart();
        nopCycles(10);
        JmpEq = 1; Zero = 1; OffsetEn = 1; Offset = 9'h1FD; applyStimulus();
        checkOutput("jmpEqBack", ProgCtr, 7);
        JmpNe = 1; Zero = 1; applyStimulus();
        checkOutput("jmpNeNotTaken", ProgCtr, 8);

        // Wrap-around
        Jmp = 1; Target = 10'd1020; applyStimulus();
        Jmp = 1; OffsetEn = 1; Offset = 9'd10; applyStimulus();
        checkOutput("wrapOffset", ProgCtr, 6);
        Jmp = 1; Target = 10'h3FF; applyStimulus();
        applyStimulus();
        checkOutput("wrapInc", ProgCtr, 0);

        // Stack overflow and underflow
        doStart();
        for (int i = 1; i <= 5; i++) begin
            Call = 1; Target = PC_W'(i * 100); applyStimulus();
        end
        checkOutput("overflowPc", ProgCtr, 500);
        checkOutput("overflowErr", StackErr, 1);
        Ret = 1; applyStimulus(); checkOutput("ret1", ProgCtr, 301);
        Ret = 1; applyStimulus(); checkOutput("ret2", ProgCtr, 201);
        Ret = 1; Call = 1; applyStimulus(); checkOutput("ret3CallIgnored", ProgCtr, 101);
        Ret = 1; applyStimulus(); checkOutput("ret4", ProgCtr, 1);
        Ret = 1; applyStimulus(); checkOutput("underflowPc", ProgCtr, 2);
        nopCycles(3);
        checkOutput("errSticky", StackErr, 1);
        doStart();
        checkOutput("errCleared", StackErr, 0);

        // Reset in the middle of a program
        Call = 1; Target = 10'd50; applyStimulus();
        Call = 1; Target = 10'd60; applyStimulus();
        nopCycles(35);
        checkOutput("midCyc", CycleCt, 37);
        Reset = 1; Start = 1; applyStimulus();
        checkOutput("midResetPc", ProgCtr, 0);
        checkOutput("midResetCyc", CycleCt, 0);
        doStart();
        Ret = 1; applyStimulus();
        checkOutput("stackEmptyAfterReset", StackErr, 1);

        // Counter saturation on the narrow instance, then restart from HALT
        doStart();
        nopCycles(20);
        Done = 1; applyStimulus();
        checkOutput("satSmall", cycleCtSmall, 15);
        checkOutput("satWide", CycleCt, 21);
        doStart();
        checkOutput("restartAck", Ack, 0);
        checkOutput("restartCyc", cycleCtSmall, 0);
        checkOutput("restartPc", ProgCtr, 0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            Reset    = ($urandom_range(0, 149) == 0);
            Start    = ($urandom_range(0, 39) == 0) || (mMode != 1 && $urandom_range(0, 3) == 0);
            Done     = ($urandom_range(0, 29) == 0);
            JmpEq    = ($urandom_range(0, 5) == 0);
            JmpNe    = ($urandom_range(0, 5) == 0);
            Jmp      = ($urandom_range(0, 7) == 0);
            Call     = ($urandom_range(0, 5) == 0);
            Ret      = ($urandom_range(0, 6) == 0);
            Zero     = 1'($urandom());
            OffsetEn = 1'($urandom());
            Offset   = OFF_W'($urandom());
            Target   = PC_W'($urandom());
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
